// File: rtl/load_store_unit.sv
// Load/store access controller for a byte-addressed 32-bit memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wd,
  output logic                  mem_we,
  input  logic [31:0]           mem_rd
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  op_we_q, op_we_d;
  logic [1:0]            op_size_q, op_size_d;
  logic                  op_signed_q, op_signed_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DW-1:0]         mem_wd_d;
  logic                  mem_we_d;
  logic                  req_ready_d;
  logic                  rsp_valid_d;
  logic [DW-1:0]         rsp_rdata_d;
  logic                  rsp_err_d;
  logic                  req_err_c;
  logic [DW-1:0]         load_ext_c;
  logic [DW-1:0]         merge_c;

  // Alignment / size check on the incoming request
  assign req_err_c = (req_size == SZ_X) ||
                     ((req_size == SZ_H) && req_addr[0]) ||
                     ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

  always_comb begin
    load_ext_c = mem_rd;
    case (op_size_q)
      SZ_B:    load_ext_c = {{24{op_signed_q & mem_rd[7]}}, mem_rd[7:0]};
      SZ_H:    load_ext_c = {{16{op_signed_q & mem_rd[15]}}, mem_rd[15:0]};
      default: load_ext_c = mem_rd;
    endcase
  end

  // Low lane of the fetched word replaced by the store data
  assign merge_c = (op_size_q == SZ_B) ? {mem_rd[31:8], wdata_q[7:0]}
                                       : {mem_rd[31:16], wdata_q};

  always_comb begin
    state_d     = state_q;
    op_we_d     = op_we_q;
    op_size_d   = op_size_q;
    op_signed_d = op_signed_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr;
    mem_wd_d    = mem_wd;
    mem_we_d    = 1'b0;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_we_d     = req_we;
          op_size_d   = req_size;
          op_signed_d = req_signed;
          wdata_d     = req_wdata[15:0];
          mem_addr_d  = req_addr;
          rsp_rdata_d = '0;
          rsp_err_d   = req_err_c;
          req_ready_d = 1'b0;
          if (req_err_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = ACCESS;
            if (req_we && (req_size == SZ_W)) begin
              mem_we_d = 1'b1;
              mem_wd_d = req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (!op_we_q) begin
          rsp_rdata_d = load_ext_c;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (op_size_q == SZ_W) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          mem_wd_d = merge_c;
          mem_we_d = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_we_q     <= 1'b0;
      op_size_q   <= 2'b00;
      op_signed_q <= 1'b0;
      wdata_q     <= '0;
      mem_addr    <= '0;
      mem_wd      <= '0;
      mem_we      <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_we_q     <= op_we_d;
      op_size_q   <= op_size_d;
      op_signed_q <= op_signed_d;
      wdata_q     <= wdata_d;
      mem_addr    <= mem_addr_d;
      mem_wd      <= mem_wd_d;
      mem_we      <= mem_we_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  logic [7:0]  tb_mem  [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ma;
  int          errors = 0;
  int          checks = 0;
  int          we_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Memory: combinational 4-byte little-endian read, synchronous 4-byte write
  assign ma = mem_addr[7:0];
  assign mem_rd = {tb_mem[8'(ma + 8'd3)], tb_mem[8'(ma + 8'd2)],
                   tb_mem[8'(ma + 8'd1)], tb_mem[ma]};

  always @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < 4; k++) tb_mem[8'(int'(ma) + k)] <= mem_wd[8*k +: 8];
  end

  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a, input bit use_ref);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = use_ref ? ref_mem[8'(int'(a) + k)] : tb_mem[8'(int'(a) + k)];
    return w;
  endfunction

  // Reference: what the access should return, and how memory should change
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_rd, output logic exp_err,
                       output int exp_lat, output int exp_we);
    logic [31:0] w;
    logic [7:0]  a;
    a       = addr[7:0];
    exp_rd  = 32'd0;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    if (exp_err) begin
      exp_lat = 0;
      exp_we  = 0;
    end else if (!we) begin
      exp_lat = 1;
      exp_we  = 0;
      w = word_at(a, 1'b1);
      if (size == 2'd0)      exp_rd = sgn ? 32'($signed(w[7:0]))  : 32'(w[7:0]);
      else if (size == 2'd1) exp_rd = sgn ? 32'($signed(w[15:0])) : 32'(w[15:0]);
      else                   exp_rd = w;
    end else begin
      exp_lat = (size == 2'd2) ? 1 : 2;
      exp_we  = 1;
      for (int k = 0; k < (1 << size); k++) ref_mem[8'(int'(a) + k)] = wdata[8*k +: 8];
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit pre, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat, exp_we, lat, n;
    model(we, size, sgn, addr, wdata, exp_rd, exp_err, exp_lat, exp_we);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = pre;
    we_cnt = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    got = rsp_rdata;
    if (!pre) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, exp_rd);
        check("hold_err", 32'(rsp_err), 32'(exp_err));
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk) rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
    check("mem_we_cycles", 32'(we_cnt), 32'(exp_we));
  endtask

  initial begin
    logic [31:0] got, addr;
    logic [1:0]  size;
    int          diffs, hold;
    bit          pre;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[16] = 8'h84; tb_mem[17] = 8'h23; tb_mem[18] = 8'hF0; tb_mem[19] = 8'h7F;
    for (int i = 16; i < 20; i++) ref_mem[i] = tb_mem[i];

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, 1'b0, got); check("lb_s_10", got, 32'hFFFFFF84);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, 1'b0, got); check("lb_u_10", got, 32'h00000084);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 1'b1, got); check("lh_s_12", got, 32'h00007FF0);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0, 1'b0, got); check("lh_s_10", got, 32'h00002384);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, got); check("lw_10", got, 32'h7FF02384);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, 1'b0, got); check("lw_mis_12", got, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, 1'b1, got); check("size3_10", got, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b0, got); check("lw_hold", got, 32'h7FF02384);

    // Reset during the read phase of a halfword store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0000BEEF;
    req_valid = 1'b1;
    we_cnt = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_mem_wd", mem_wd, 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_we_cnt", 32'(we_cnt), 32'd0);
    check("mid_rst_word10", word_at(8'h10, 1'b0), 32'h7FF02384);

    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 0, 1'b0, got);
    check("sb_11_word10", word_at(8'h10, 1'b0), 32'h7FF0AB84);

    for (int t = 0; t < 300; t++) begin
      size = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      hold = $urandom_range(0, 3);
      pre  = (hold == 0) && ($urandom_range(0, 1) == 1);
      do_req(1'($urandom), size, 1'($urandom), addr, $urandom, hold, pre, got);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    check("mem_bytes_differing", 32'(diffs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
